// File: rtl/cpu6_pipereg_hs_if.sv
// Valid/ready stage-boundary bundle for one cpu6 pipeline register: upstream
// channel (in_*) and downstream channel (out_*). The register itself uses the slave view.
interface cpu6_pipereg_hs_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cpu6_pipereg_hs.sv
// Handshaked cpu6 pipeline register: one main entry plus an optional skid entry
// that registers in_ready, with a squashing flush and occupancy status.
module cpu6_pipereg_hs #(
  parameter int DW            = 32,
  parameter bit SKID          = 1'b1,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  cpu6_pipereg_hs_if.slave    bus,
  output logic [1:0]          count,
  output logic                empty
);

  // Encoding equals the number of held entries, so count is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_d, skid_d;
  logic          main_v, skid_v;
  logic          in_fire, out_fire;
  logic          load_main, load_skid, move_skid;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  // With the skid entry, in_ready depends only on state, cutting the
  // combinational path from out_ready back to the upstream stage.
  assign bus.in_ready  = SKID ? ~skid_v : (~main_v | bus.out_ready);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = main_v & bus.out_ready;

  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d & {DW{main_v}};
  assign count         = state_q;
  assign empty         = ~main_v;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          // Only reachable with SKID=1: without skid, in_fire in ONE implies out_fire.
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          move_skid = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A beat accepted during flush is consumed upstream but never stored.
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || (flush && ZERO_ON_FLUSH)) begin
      main_d <= '0;
      skid_d <= '0;
    end else begin
      if (load_main)      main_d <= bus.in_data;
      else if (move_skid) main_d <= skid_d;
      if (load_skid)      skid_d <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_cpu6_pipereg_hs.sv
// Directed bench for cpu6_pipereg_hs: one SKID=1 and one SKID=0 instance,
// each scenario in its own task with hand-computed expected values.
module tb_cpu6_pipereg_hs;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush1, flush0;
  logic [1:0] count1, count0;
  logic empty1, empty0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu6_pipereg_hs_if #(.DW(DW)) hs1 ();
  cpu6_pipereg_hs_if #(.DW(DW)) hs0 ();

  cpu6_pipereg_hs #(.DW(DW), .SKID(1'b1), .ZERO_ON_FLUSH(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .bus(hs1.slave),
    .count(count1), .empty(empty1)
  );

  cpu6_pipereg_hs #(.DW(DW), .SKID(1'b0), .ZERO_ON_FLUSH(1'b1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .bus(hs0.slave),
    .count(count0), .empty(empty0)
  );

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
    hs1.in_valid = 1'b1; hs1.in_data = 32'hDEADBEEF; hs1.out_ready = 1'b0;
    hs0.in_valid = 1'b1; hs0.in_data = 32'hDEADBEEF; hs0.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (hs1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc%0d got=%b exp=0", c, hs1.out_valid); end
      checks++; if (hs1.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data cyc%0d got=%h exp=0", c, hs1.out_data); end
      checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL reset_count cyc%0d got=%0d exp=0", c, count1); end
      checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty cyc%0d got=%b exp=1", c, empty1); end
      checks++; if (hs1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready cyc%0d got=%b exp=1", c, hs1.in_ready); end
      checks++; if (hs0.out_valid !== 1'b0 || count0 !== 2'd0 || hs0.in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_skid0 cyc%0d out_valid=%b count=%0d in_ready=%b exp=0/0/1", c, hs0.out_valid, count0, hs0.in_ready);
      end
    end
    // First accept happens on the edge after reset is released.
    reset = 1'b0; hs0.in_valid = 1'b0;
    tick();
    checks++; if (hs1.out_valid !== 1'b1 || hs1.out_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL first_accept got valid=%b data=%h exp valid=1 data=deadbeef", hs1.out_valid, hs1.out_data);
    end
    hs1.in_valid = 1'b0; hs1.out_ready = 1'b1;
    tick();
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL first_drain_empty got=%b exp=1", empty1); end
  endtask

  task automatic test_streaming();
    hs1.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      hs1.in_valid = 1'b1; hs1.in_data = 32'(i);
      checks++; if (hs1.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat%0d got=%b exp=1", i, hs1.in_ready); end
      tick();
      checks++; if (hs1.out_valid !== 1'b1 || hs1.out_data !== 32'(i)) begin
        errors++; $display("FAIL stream_out beat%0d got valid=%b data=%h exp valid=1 data=%h", i, hs1.out_valid, hs1.out_data, 32'(i));
      end
      checks++; if (count1 !== 2'd1) begin errors++; $display("FAIL stream_count beat%0d got=%0d exp=1", i, count1); end
    end
    hs1.in_valid = 1'b0;
    tick();
    checks++; if (empty1 !== 1'b1 || count1 !== 2'd0) begin errors++; $display("FAIL stream_drain got empty=%b count=%0d exp 1/0", empty1, count1); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    hs1.out_ready = 1'b0;
    hs1.in_valid = 1'b1; hs1.in_data = 32'h10;
    tick();
    checks++; if (count1 !== 2'd1 || hs1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_first got count=%0d in_ready=%b exp 1/1", count1, hs1.in_ready); end
    hs1.in_data = 32'h11;
    tick();
    checks++; if (count1 !== 2'd2 || hs1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got count=%0d in_ready=%b exp 2/0", count1, hs1.in_ready); end
    hs1.in_data = 32'h12;
    tick();
    checks++; if (count1 !== 2'd2 || hs1.in_ready !== 1'b0 || hs1.out_data !== 32'h10) begin
      errors++; $display("FAIL bp_hold got count=%0d in_ready=%b data=%h exp 2/0/10", count1, hs1.in_ready, hs1.out_data);
    end
    // Release: collect every beat that transfers downstream.
    hs1.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (hs1.out_valid) got_q.push_back(hs1.out_data);
      if (hs1.in_valid && hs1.in_ready) hs1.in_valid = 1'b1;
      tick();
      if (hs1.in_valid && hs1.in_data == 32'h12 && count1 == 2'd1 && hs1.out_data == 32'h12) hs1.in_valid = 1'b0;
    end
    hs1.in_valid = 1'b0;
    exp_q = '{32'h10, 32'h11, 32'h12};
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_order_count got=%0d beats exp=3", got_q.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_order beat%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 32'hx, exp_q[k]);
      end
    end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL bp_drain_empty got=%b exp=1", empty1); end
  endtask

  task automatic test_flush_full();
    hs1.out_ready = 1'b0;
    hs1.in_valid = 1'b1; hs1.in_data = 32'h10;
    tick();
    hs1.in_data = 32'h11;
    tick();
    checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL flush_prefill got count=%0d exp=2", count1); end
    flush1 = 1'b1; hs1.in_data = 32'h99;
    tick();
    flush1 = 1'b0; hs1.in_valid = 1'b0; hs1.out_ready = 1'b1;
    checks++; if (hs1.out_valid !== 1'b0 || hs1.out_data !== 32'h0) begin
      errors++; $display("FAIL flush_full_out got valid=%b data=%h exp 0/0", hs1.out_valid, hs1.out_data);
    end
    checks++; if (count1 !== 2'd0 || empty1 !== 1'b1 || hs1.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full_status got count=%0d empty=%b in_ready=%b exp 0/1/1", count1, empty1, hs1.in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (hs1.out_valid !== 1'b0 || hs1.out_data === 32'h99) begin
        errors++; $display("FAIL flush_squashed cyc%0d got valid=%b data=%h exp valid=0", c, hs1.out_valid, hs1.out_data);
      end
    end
    // Cycle after flush accepts normally.
    hs1.in_valid = 1'b1; hs1.in_data = 32'h55; hs1.out_ready = 1'b0;
    tick();
    hs1.in_valid = 1'b0;
    checks++; if (hs1.out_valid !== 1'b1 || hs1.out_data !== 32'h55) begin
      errors++; $display("FAIL post_flush_accept got valid=%b data=%h exp 1/55", hs1.out_valid, hs1.out_data);
    end
    hs1.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush_out_fire();
    hs1.out_ready = 1'b0;
    hs1.in_valid = 1'b1; hs1.in_data = 32'h20;
    tick();
    hs1.in_valid = 1'b0;
    hs1.out_ready = 1'b1; flush1 = 1'b1;
    #1;
    checks++; if (hs1.out_valid !== 1'b1 || hs1.out_data !== 32'h20) begin
      errors++; $display("FAIL flush_fire_xfer got valid=%b data=%h exp 1/20", hs1.out_valid, hs1.out_data);
    end
    tick();
    flush1 = 1'b0;
    checks++; if (hs1.out_valid !== 1'b0 || count1 !== 2'd0 || empty1 !== 1'b1) begin
      errors++; $display("FAIL flush_fire_empty got valid=%b count=%0d empty=%b exp 0/0/1", hs1.out_valid, count1, empty1);
    end
  endtask

  task automatic test_skid0();
    hs0.out_ready = 1'b0;
    hs0.in_valid = 1'b1; hs0.in_data = 32'hA1;
    tick();
    checks++; if (hs0.in_ready !== 1'b0 || count0 !== 2'd1 || hs0.out_data !== 32'hA1) begin
      errors++; $display("FAIL s0_full got in_ready=%b count=%0d data=%h exp 0/1/a1", hs0.in_ready, count0, hs0.out_data);
    end
    hs0.out_ready = 1'b1;
    #1;
    checks++; if (hs0.in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb_ready got=%b exp=1", hs0.in_ready); end
    for (int i = 1; i <= 4; i++) begin
      hs0.in_valid = 1'b1; hs0.in_data = 32'(i);
      tick();
      checks++; if (hs0.out_valid !== 1'b1 || hs0.out_data !== 32'(i) || count0 !== 2'd1) begin
        errors++; $display("FAIL s0_stream beat%0d got valid=%b data=%h count=%0d exp 1/%h/1", i, hs0.out_valid, hs0.out_data, count0, 32'(i));
      end
    end
    hs0.in_valid = 1'b0;
    tick();
    checks++; if (empty0 !== 1'b1 || hs0.out_data !== 32'h0) begin
      errors++; $display("FAIL s0_drain got empty=%b data=%h exp 1/0", empty0, hs0.out_data);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_out_fire();
    test_skid0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/cpu6_pipereg_hs.md
# cpu6_pipereg_hs

Parametrised, handshaked pipeline register for the cpu6 pipeline, replacing the fixed always-advance stage registers. It carries one packed payload bus between two stages and adds valid/ready flow control, an optional two-entry skid buffer that registers the upstream ready path, and a squashing flush. Stage-boundary control (empty-pipeline requests, CSR ordering) uses its occupancy and empty status. One instance sits at each stage boundary, starting with EX/MEM.

## Interface
- DW, 32: payload width in bits; the caller packs all stage fields into one bus.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- ZERO_ON_FLUSH, 1: 1 = payload registers clear to 0 on reset and flush; 0 = only valid bits clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries; highest priority after reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; a transfer happens when in_valid and in_ready are both high (in_fire).
- in_data  in  DW  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts; a transfer happens when out_valid and out_ready are both high (out_fire).
- out_data  out  DW  head payload; forced to 0 whenever out_valid is 0.
- count  out  2  number of held entries, 0..2 (0..1 when SKID=0).
- empty  out  1  count == 0.

## Operation
- State: the main entry (main_v, main_d) and, when SKID=1, a skid entry (skid_v, skid_d). out_valid = main_v and out_data = main_d & {DW{main_v}}.
- Ordering is strict FIFO. An entry is never duplicated or dropped except by flush.
- With SKID=1, in_ready = ~skid_v, a purely registered signal with no combinational path from out_ready.
  - EMPTY (count 0): in_fire loads main; next state is ONE.
  - ONE: in_fire and out_fire together load main with in_data; state stays ONE. in_fire alone loads skid; next state is FULL. out_fire alone gives EMPTY.
  - FULL: in_ready = 0. out_fire moves skid to main and clears skid_v; next state is ONE. Otherwise the state holds.
- With SKID=0, in_ready = ~main_v | out_ready. in_fire loads main; out_fire without in_fire clears main_v.
- Flush: main_v and skid_v both clear on the next edge.
  - An in_fire in the same cycle is discarded.
  - Upstream still sees in_ready as it was that cycle; the beat counts as consumed and is squashed.
  - If ZERO_ON_FLUSH=1, main_d and skid_d clear to 0.
  - An out_fire in the flush cycle still completes downstream.
- Reset has the same effect as flush, with payloads always cleared to 0. Reset wins over flush.
- Payload registers load only on their load condition and otherwise hold. They carry no enable glitching and have no X-propagation dependence on invalid data.

## Timing
- Reset values: out_valid 0, out_data 0, count 0, empty 1, in_ready 1.
- Latency: data accepted at edge N appears on out_data after edge N, i.e. one cycle.
- Throughput is one beat per cycle when out_ready stays high, in both SKID modes.
- With SKID=1, out_ready falling stalls upstream after at most one extra accepted beat; in_ready falls on the edge that fills skid.
- count and empty are registered-state derived and update on the same edge as the valid bits.
- Flush asserted in cycle N gives out_valid = 0, count = 0 and empty = 1 in cycle N+1. in_valid in cycle N+1 is accepted normally.
- Simultaneous in_fire and out_fire in FULL cannot occur because in_ready is 0 in FULL.

## Test plan
- Reset: hold reset 2 cycles with in_valid = 1 and in_data = 0xDEADBEEF. Required: out_valid 0, out_data 0, count 0, empty 1 and in_ready 1 throughout. The first accept happens after reset deasserts.
- Streaming (SKID=1): send 0x1..0x8 back-to-back with out_ready = 1. Required: out_data shows 0x1..0x8 on 8 consecutive cycles, one cycle behind the inputs, with count staying at 1.
- Backpressure: stream 0x10, 0x11, 0x12 with out_ready = 0. Required: 0x10 and 0x11 are accepted, then in_ready = 0 with count = 2. With out_ready = 1 afterwards, the outputs are 0x10, 0x11, 0x12 in order, with nothing lost or duplicated.
- Flush when FULL: after the backpressure fill, assert flush with in_valid = 1 and in_data = 0x99. Required next cycle: out_valid 0, out_data 0, count 0, empty 1; 0x99 never appears at the output.
- Flush concurrent with out_fire in state ONE holding 0x20: required that 0x20 transfers that cycle and the stage is empty the next cycle.
- SKID=0 variant: with out_ready = 0 and main full, required in_ready = 0. Raising out_ready makes in_ready 1 in the same cycle. Streaming 0x1..0x4 gives full throughput with count never exceeding 1.
